// File: rtl/twitchcore_pkg.sv
// Shared definitions for the twitchcore data-memory path: RV32I size codes,
// responder FSM states, default memory base and the request legality check.
package twitchcore_pkg;

   // RV32I load/store funct3 size codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte address of data-memory word 0
   localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dmem_state_e;

   // Fault when out of range, misaligned for its size, or an illegal size code
   function automatic logic dmem_fault(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo,
                                       input logic       oor);
      logic f;
      f = oor;
      case (f3)
         F3_B:    f = oor;
         F3_H:    f = oor | lo[0];
         F3_W:    f = oor | (lo != 2'b00);
         F3_BU:   f = oor | we;
         F3_HU:   f = oor | we | lo[0];
         default: f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous read and per-byte write enables.
// Contents are deliberately not reset.
module dmem_ram #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned IDX_W       = 12
) (
   input  logic             clk,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane write and registered read (read returns pre-write contents)
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, checks it for
// faults, accesses the word RAM and returns a single held response.
module dmem_responder
   import twitchcore_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

   dmem_state_e      state;
   logic             we_q;
   logic [2:0]       f3_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic [31:0]      sel_addr_c;
   logic [IDX_W-1:0] ram_idx_c;
   logic [31:0]      off_c;
   logic             fault_c;
   logic [3:0]       lane_be_c;
   logic [31:0]      lane_wdata_c;
   logic [3:0]       ram_be_c;
   logic [31:0]      ram_rdata;
   logic [31:0]      shifted_c;
   logic [31:0]      load_c;

   // RAM is addressed by the incoming request in IDLE so read data is ready in ACCESS
   always_comb begin
      sel_addr_c = (state == ST_IDLE) ? req_addr : addr_q;
      ram_idx_c  = IDX_W'((sel_addr_c - BASE_ADDR) >> 2);
      off_c      = addr_q - BASE_ADDR;
      fault_c    = dmem_fault(we_q, f3_q, addr_q[1:0], off_c >= SPAN_BYTES);
   end

   // Store lane selection; data replicated so each lane carries the low bytes
   always_comb begin
      lane_be_c    = 4'b0000;
      lane_wdata_c = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            lane_be_c    = 4'b0001 << addr_q[1:0];
            lane_wdata_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            lane_be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata_c = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            lane_be_c    = 4'b1111;
            lane_wdata_c = wdata_q;
         end
         default: begin
            lane_be_c    = 4'b0000;
            lane_wdata_c = wdata_q;
         end
      endcase
      ram_be_c = (state == ST_ACCESS && we_q && !fault_c) ? lane_be_c : 4'b0000;
   end

   // Load extraction and extension; stores and faults return zero
   always_comb begin
      shifted_c = ram_rdata >> {addr_q[1:0], 3'b000};
      load_c    = 32'h0;
      case (f3_q)
         F3_B:    load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         F3_H:    load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         F3_W:    load_c = shifted_c;
         F3_BU:   load_c = {24'h0, shifted_c[7:0]};
         F3_HU:   load_c = {16'h0, shifted_c[15:0]};
         default: load_c = 32'h0;
      endcase
      if (fault_c || we_q) begin
         load_c = 32'h0;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .be    (ram_be_c),
      .addr  (ram_idx_c),
      .wdata (lane_wdata_c),
      .rdata (ram_rdata)
   );

   // Request/response FSM with registered handshake and response outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_fault <= 1'b0;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  f3_q      <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  state     <= ST_ACCESS;
                  req_ready <= 1'b0;
               end
            end
            ST_ACCESS: begin
               state     <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_rdata <= load_c;
               rsp_fault <= fault_c;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset and
// back-pressure sequences, then random traffic against a byte-level model.
module tb_dmem_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
   localparam logic [31:0] RGN   = 32'h8000_0100;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   int checks   = 0;
   int failures = 0;

   logic [7:0] bmem [logic [31:0]];

   typedef struct {
      string       nm;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_flt;
   } vec_t;

   vec_t vt[$];

   dmem_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Access size in bytes, 0 for an unknown size code
   function automatic int msize(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic mfault(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] off;
      int sz;
      bit legal;
      off = a - BASE;
      sz  = msize(f3);
      if (off >= SPAN) return 1'b1;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      if ((a % sz) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v;
      int sz;
      sz = msize(f3);
      v  = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(bmem[a + 32'(i)]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic mstore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < msize(f3); i++) bmem[a + 32'(i)] = 8'(wd >> (8 * i));
   endtask

   // One full transaction from an idle DUT, with junk requests while busy
   task automatic xact(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eflt, input int hold);
      int lat;
      chk({nm, ":req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = RGN | ($urandom & 32'h3C);
      req_wdata  = $urandom;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 10) begin
         chk({nm, ":req_ready_busy"}, 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, ":latency"}, 32'(lat), 32'd2);
      chk({nm, ":rdata"}, rsp_rdata, erd);
      chk({nm, ":fault"}, 32'(rsp_fault), 32'(eflt));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, ":hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({nm, ":hold_rdata"}, rsp_rdata, erd);
         chk({nm, ":hold_fault"}, 32'(rsp_fault), 32'(eflt));
         chk({nm, ":hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({nm, ":post_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, ":post_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   // Reset asserted while a response is pending drops it without a handshake
   task automatic reset_in_resp(input string nm, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] erd, input logic eflt);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a; req_wdata = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk({nm, ":resp_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, ":resp_rdata"}, rsp_rdata, erd);
      chk({nm, ":resp_fault"}, 32'(rsp_fault), 32'(eflt));
      resetn = 1'b0; #1;
      chk({nm, ":rst_valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, ":rst_rdata"}, rsp_rdata, 32'h0);
      chk({nm, ":rst_fault"}, 32'(rsp_fault), 32'd0);
      chk({nm, ":rst_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk({nm, ":after_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [2:0]  f3;
      logic        we;
      logic        ef;
      logic [31:0] er;

      resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
      #12;
      chk("reset:req_ready", 32'(req_ready), 32'd1);
      chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset:rsp_rdata", rsp_rdata, 32'h0);
      chk("reset:rsp_fault", 32'(rsp_fault), 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      vt.push_back('{"sw_beef",     1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0});
      vt.push_back('{"lw_beef",     1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vt.push_back('{"sb_aa",       1'b1, 3'b000, 32'h8000_0011, 32'h0000_00AA, 32'h0,         1'b0});
      vt.push_back('{"lw_merged",   1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0});
      vt.push_back('{"lb_aa",       1'b0, 3'b000, 32'h8000_0011, 32'h0,         32'hFFFF_FFAA, 1'b0});
      vt.push_back('{"lbu_aa",      1'b0, 3'b100, 32'h8000_0011, 32'h0,         32'h0000_00AA, 1'b0});
      vt.push_back('{"lh_dead",     1'b0, 3'b001, 32'h8000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0});
      vt.push_back('{"lhu_dead",    1'b0, 3'b101, 32'h8000_0012, 32'h0,         32'h0000_DEAD, 1'b0});
      vt.push_back('{"lh_misalign", 1'b0, 3'b001, 32'h8000_0013, 32'h0,         32'h0,         1'b1});
      vt.push_back('{"sw_misalign", 1'b1, 3'b010, 32'h8000_0012, 32'h1234_5678, 32'h0,         1'b1});
      vt.push_back('{"lw_unchanged",1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0});
      vt.push_back('{"lw_below",    1'b0, 3'b010, 32'h7FFF_FFFC, 32'h0,         32'h0,         1'b1});
      vt.push_back('{"lw_above",    1'b0, 3'b010, 32'h8000_4000, 32'h0,         32'h0,         1'b1});
      vt.push_back('{"sw_top",      1'b1, 3'b010, 32'h8000_3FFC, 32'h0BAD_F00D, 32'h0,         1'b0});
      vt.push_back('{"lw_top",      1'b0, 3'b010, 32'h8000_3FFC, 32'h0,         32'h0BAD_F00D, 1'b0});
      vt.push_back('{"ld_f3_011",   1'b0, 3'b011, 32'h8000_0010, 32'h0,         32'h0,         1'b1});
      vt.push_back('{"ld_f3_110",   1'b0, 3'b110, 32'h8000_0010, 32'h0,         32'h0,         1'b1});
      vt.push_back('{"st_f3_100",   1'b1, 3'b100, 32'h8000_0010, 32'h0000_0011, 32'h0,         1'b1});
      vt.push_back('{"st_f3_101",   1'b1, 3'b101, 32'h8000_0010, 32'h0000_2233, 32'h0,         1'b1});
      vt.push_back('{"lw_still",    1'b0, 3'b010, 32'h8000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0});
      vt.push_back('{"sh_upper",    1'b1, 3'b001, 32'h8000_0016, 32'hFFFF_55AA, 32'h0,         1'b0});
      vt.push_back('{"lhu_upper",   1'b0, 3'b101, 32'h8000_0016, 32'h0,         32'h0000_55AA, 1'b0});
      vt.push_back('{"sw_prior",    1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 32'h0,         1'b0});

      foreach (vt[i]) xact(vt[i].nm, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
                           vt[i].exp_rd, vt[i].exp_flt, 0);

      // Back-pressure: response held for five cycles
      xact("lw_hold5", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, 5);

      // Reset during ACCESS of a store: store must be lost
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h8000_0020; req_wdata = 32'h1122_3344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_access:req_ready", 32'(req_ready), 32'd0);
      resetn = 1'b0; #1;
      chk("rst_access:rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_access:req_ready_rst", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("rst_access:idle_valid", 32'(rsp_valid), 32'd0);
      xact("lw_prior", 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

      reset_in_resp("rst_resp_data",  3'b010, 32'h8000_0010, 32'hDEAD_AAEF, 1'b0);
      reset_in_resp("rst_resp_fault", 3'b001, 32'h8000_0013, 32'h0,         1'b1);
      xact("lw_after_rst", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, 0);

      // Random traffic: seed the 16-word region, then mixed requests
      for (int w = 0; w < 16; w++) begin
         a  = RGN + 32'(4 * w);
         wd = $urandom;
         xact("rnd_init", 1'b1, 3'b010, a, wd, 32'h0, 1'b0, 0);
         mstore(3'b010, a, wd);
      end
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         wd = $urandom;
         case ($urandom_range(0, 9))
            0:       a = BASE + SPAN + 32'($urandom_range(0, 255));
            1:       a = BASE - 32'($urandom_range(1, 256));
            default: a = RGN + 32'($urandom_range(0, 63));
         endcase
         ef = mfault(we, f3, a);
         er = (ef || we) ? 32'h0 : mload(f3, a);
         xact("rnd", we, f3, a, wd, er, ef, int'($urandom_range(0, 2)));
         if (we && !ef) mstore(f3, a, wd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL global_timeout actual=%0d expected=done", checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
